mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and transaction sequencer that shares one memory port between the instruction-fetch path and the load/store data path of the RISC-V core. It serializes requests, moves one transaction at a time through a request/accept/response FSM, and routes each response back to its owner. It also enforces a response timeout. The block sits between the program-counter/fetch logic, the data-memory access logic, and a single unified memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 (byte enables are 4 bits)
- TIMEOUT_CYCLES, 255, maximum cycles from entering ISSUE to response; 0 disables the timeout

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response pulse
- if_rdata  out  DATA_W  fetched word
- if_err  out  1  fetch timed out (qualifies if_rvalid)
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response pulse; also marks store completion
- d_rdata  out  DATA_W  load data
- d_err  out  1  data access timed out (qualifies d_rvalid)
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  4  memory byte enables
- m_ack  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response; earliest one cycle after m_ack
- m_rdata  in  DATA_W  memory read data

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate among if_req and d_req.
  - Only one requesting: grant it.
  - Both requesting: grant the port not granted most recently (round-robin).
  - x_gnt is combinational and high for exactly that cycle. The winner's fields are captured at the edge, and the FSM moves to ISSUE.
  - A fetch is captured with we = 0 and be = 4'hF.
  - The requester may drop or change its request after the gnt cycle.
- **ISSUE:**
  - m_req = 1, with m_we/m_addr/m_wdata/m_be driven from the captured registers.
  - m_ack = 1 moves the FSM to WAIT.
- **WAIT:**
  - m_req = 0.
  - m_rvalid = 1 captures m_rdata (or zero for a store), clears err, and moves the FSM to RESP.
- **Timeout:**
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT_CYCLES (if nonzero), the FSM moves to RESP with err = 1 and rdata = 0, and m_req drops.
- **RESP:**
  - The owner's x_rvalid = 1 for one cycle, with x_rdata and x_err valid.
  - The FSM then returns to IDLE.
  - The non-owner's rvalid, rdata, and err stay 0.
- **Last-owner register:** updated at each grant. Reset value is "data", so the first tie goes to fetch.
- **Ignored inputs:** m_rvalid in IDLE, ISSUE, or RESP, and m_ack outside ISSUE, are ignored. m_rvalid arriving after a timeout is therefore dropped.
- **Single outstanding:** only one transaction is in flight. No new grant is made until the FSM is back in IDLE.

## Timing
- **Reset:**
  - State goes to IDLE and the counter to 0.
  - All outputs are 0: gnt, rvalid, rdata, err, m_req, m_we, m_addr, m_wdata, m_be.
  - A reset mid-transaction abandons it with no response pulse.
- **Minimum latency:**
  - gnt in cycle 0.
  - m_req in cycle 1 (ack in cycle 1).
  - m_rvalid in cycle 2.
  - x_rvalid in cycle 3.
  - Next grant possible in cycle 4.
- **Memory stall:** each extra cycle of m_ack or m_rvalid delay adds one cycle.
- **Timeout:**
  - err rvalid appears TIMEOUT_CYCLES + 1 cycles after the ISSUE entry edge.
  - Exact boundary: a response with m_rvalid on the same cycle the counter reaches TIMEOUT_CYCLES is treated as a success, not a timeout.
- **Output stability:** m_* outputs are stable throughout ISSUE. x_rdata and x_err are registered and held only during RESP; they are 0 otherwise.

## Test plan
- **Fetch, zero wait:** if_req at addr 0x10, memory acks immediately and returns 0x00500093 next cycle -> if_gnt in cycle 0, m_req in cycle 1, if_rvalid with if_rdata = 0x00500093 in cycle 3, if_err = 0.
- **Store:** d_req with we = 1, addr 0x40, wdata 0xDEADBEEF, be 4'b0011 -> m_we = 1, m_be = 4'b0011, m_wdata = 0xDEADBEEF during ISSUE; d_rvalid pulse with d_rdata = 0.
- **Round-robin fairness:** if_req and d_req both held high for 4 transactions after reset -> grant order is fetch, data, fetch, data; no rvalid is ever routed to the wrong port.
- **Timeout:** TIMEOUT_CYCLES = 5, memory never acks -> m_req held for 5 cycles then drops, d_err = 1 and d_rvalid = 1 six cycles after ISSUE entry, rdata = 0. A late m_rvalid afterwards is ignored.
- **Memory stall:** ack delayed 3 cycles and rvalid delayed 2 more -> m_fields stable throughout; response arrives 5 cycles later than the zero-wait case.
- **Reset mid-WAIT:** rst asserted while in WAIT -> all outputs 0 immediately; no rvalid pulse; after release, a pending tie is granted to fetch first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. Round-robin arbitration in IDLE, then one transaction at a time
// through ISSUE -> WAIT -> RESP, with an optional response timeout.
//
// Handshakes: x_gnt is a single-cycle combinational accept while IDLE; the
// winner's fields are captured on that edge. m_req is held until m_ack
// (ISSUE only). m_rvalid is honoured only in WAIT. x_rvalid is a one-cycle
// pulse in RESP, qualified by x_err; x_rdata/x_err are zero outside RESP.
// DATA_W must be 32 because byte enables are fixed at 4 bits.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Counter value at which the transaction is abandoned.
    localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT_CYCLES);
    // One cycle earlier: m_req is dropped so it is low in the limit cycle.
    localparam logic [CNT_W-1:0] T_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    logic                last_d_q;   // 1: data port was granted most recently
    logic                owner_d_q;  // 1: in-flight transaction belongs to data port
    logic [CNT_W-1:0]    cnt_q;
    logic                m_req_q;
    logic                m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [3:0]          m_be_q;
    logic                if_rvalid_q, d_rvalid_q;
    logic                if_err_q, d_err_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    logic                gnt_if_d, gnt_d_d;
    logic                to_hit_d, to_pre_d;
    logic [DATA_W-1:0]   resp_data_d;

    // Arbitration and timeout decode; grants are suppressed while reset is held.
    always_comb begin
        gnt_if_d    = !rst && (state_q == S_IDLE) && if_req && (!d_req || last_d_q);
        gnt_d_d     = !rst && (state_q == S_IDLE) && d_req && (!if_req || !last_d_q);
        to_hit_d    = TO_EN && (cnt_q == T_LIM);
        to_pre_d    = TO_EN && (cnt_q == T_PRE);
        resp_data_d = m_we_q ? '0 : m_rdata;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b1;
            owner_d_q   <= 1'b0;
            cnt_q       <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_be_q      <= 4'h0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_if_d || gnt_d_d) begin
                        owner_d_q <= gnt_d_d;
                        last_d_q  <= gnt_d_d;
                        cnt_q     <= '0;
                        m_req_q   <= 1'b1;
                        state_q   <= S_ISSUE;
                        if (gnt_d_d) begin
                            m_we_q    <= d_we;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            m_be_q    <= d_be;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= if_addr;
                            m_wdata_q <= '0;
                            m_be_q    <= 4'hF;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (to_hit_d) begin
                        m_req_q <= 1'b0;
                        state_q <= S_RESP;
                        if (owner_d_q) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= '0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_err_q    <= 1'b1;
                            if_rdata_q  <= '0;
                        end
                    end else if (m_ack) begin
                        m_req_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else if (to_pre_d) begin
                        m_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A response in the limit cycle still counts as success.
                    if (m_rvalid || to_hit_d) begin
                        state_q <= S_RESP;
                        if (owner_d_q) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= !m_rvalid;
                            d_rdata_q  <= m_rvalid ? resp_data_d : '0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_err_q    <= !m_rvalid;
                            if_rdata_q  <= m_rvalid ? resp_data_d : '0;
                        end
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    if_err_q    <= 1'b0;
                    d_err_q     <= 1'b0;
                    if_rdata_q  <= '0;
                    d_rdata_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_gnt    = gnt_if_d;
    assign d_gnt     = gnt_d_d;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with the default timeout
// and one with TIMEOUT_CYCLES = 5, driven from shared inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        m_ack = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, m_req, m_we;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [1:0]  dbg_state;

    logic        t_if_gnt, t_if_rvalid, t_if_err, t_d_gnt, t_d_rvalid, t_d_err, t_m_req, t_m_we;
    logic [31:0] t_if_rdata, t_d_rdata, t_m_addr, t_m_wdata;
    logic [3:0]  t_m_be;
    logic [1:0]  t_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock and reset block
    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(5)) dut_t (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(t_if_gnt),
        .if_rvalid(t_if_rvalid), .if_rdata(t_if_rdata), .if_err(t_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(t_d_gnt), .d_rvalid(t_d_rvalid), .d_rdata(t_d_rdata), .d_err(t_d_err),
        .m_req(t_m_req), .m_we(t_m_we), .m_addr(t_m_addr), .m_wdata(t_m_wdata), .m_be(t_m_be),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .dbg_state(t_dbg_state)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One zero-wait transaction with both requests held (fetch @0x100, load @0x200).
    task automatic rr_step(input bit exp_fetch, input logic [31:0] rd);
        #1;
        chk("rr_if_gnt", 64'(if_gnt), 64'(exp_fetch));
        chk("rr_d_gnt", 64'(d_gnt), 64'(!exp_fetch));
        tick();
        m_ack = 1'b1;
        #1;
        chk("rr_m_req", 64'(m_req), 64'd1);
        chk("rr_m_addr", 64'(m_addr), exp_fetch ? 64'h100 : 64'h200);
        chk("rr_no_gnt", 64'(if_gnt | d_gnt), 64'd0);
        tick();
        m_ack = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = rd;
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("rr_if_rvalid", 64'(if_rvalid), 64'(exp_fetch));
        chk("rr_d_rvalid", 64'(d_rvalid), 64'(!exp_fetch));
        chk("rr_if_rdata", 64'(if_rdata), exp_fetch ? 64'(rd) : 64'd0);
        chk("rr_d_rdata", 64'(d_rdata), exp_fetch ? 64'd0 : 64'(rd));
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_be", 64'(m_be), 64'd0);
        chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        rst = 1'b0;
        tick();

        // Fetch, zero wait
        if_req = 1'b1;
        if_addr = 32'h10;
        #1;
        chk("f_if_gnt", 64'(if_gnt), 64'd1);
        chk("f_d_gnt", 64'(d_gnt), 64'd0);
        chk("f_m_req_c0", 64'(m_req), 64'd0);
        tick();
        if_req = 1'b0;
        m_ack = 1'b1;
        #1;
        chk("f_m_req_c1", 64'(m_req), 64'd1);
        chk("f_m_addr", 64'(m_addr), 64'h10);
        chk("f_m_we", 64'(m_we), 64'd0);
        chk("f_m_be", 64'(m_be), 64'hF);
        tick();
        m_ack = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h00500093;
        #1;
        chk("f_m_req_c2", 64'(m_req), 64'd0);
        chk("f_if_rvalid_c2", 64'(if_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("f_if_rvalid_c3", 64'(if_rvalid), 64'd1);
        chk("f_if_rdata", 64'(if_rdata), 64'h00500093);
        chk("f_if_err", 64'(if_err), 64'd0);
        chk("f_d_rvalid", 64'(d_rvalid), 64'd0);
        tick();
        chk("f_if_rvalid_c4", 64'(if_rvalid), 64'd0);
        chk("f_if_rdata_c4", 64'(if_rdata), 64'd0);
        chk("f_state_c4", 64'(dbg_state), 64'd0);

        // Store
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h40;
        d_wdata = 32'hDEADBEEF;
        d_be = 4'b0011;
        #1;
        chk("s_d_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0;
        m_ack = 1'b1;
        #1;
        chk("s_m_req", 64'(m_req), 64'd1);
        chk("s_m_we", 64'(m_we), 64'd1);
        chk("s_m_be", 64'(m_be), 64'h3);
        chk("s_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
        chk("s_m_addr", 64'(m_addr), 64'h40);
        tick();
        m_ack = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h12345678;
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("s_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("s_d_rdata", 64'(d_rdata), 64'd0);
        chk("s_d_err", 64'(d_err), 64'd0);
        chk("s_if_rvalid", 64'(if_rvalid), 64'd0);
        tick();
        d_we = 1'b0;

        // Memory stall: ack after 3 extra cycles, rvalid 2 further cycles late
        if_req = 1'b1;
        if_addr = 32'h20;
        #1;
        chk("st_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 1'b0;
        if_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_m_req_hold", 64'(m_req), 64'd1);
            chk("st_m_addr_hold", 64'(m_addr), 64'h20);
            chk("st_m_be_hold", 64'(m_be), 64'hF);
            tick();
        end
        m_ack = 1'b1;
        #1;
        chk("st_m_req_ack", 64'(m_req), 64'd1);
        chk("st_m_addr_ack", 64'(m_addr), 64'h20);
        tick();
        m_ack = 1'b0;
        #1;
        chk("st_m_req_wait", 64'(m_req), 64'd0);
        chk("st_if_rvalid_c5", 64'(if_rvalid), 64'd0);
        tick();
        chk("st_if_rvalid_c6", 64'(if_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b1;
        m_rdata = 32'hA5A50F0F;
        #1;
        chk("st_if_rvalid_c7", 64'(if_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("st_if_rvalid_c8", 64'(if_rvalid), 64'd1);
        chk("st_if_rdata", 64'(if_rdata), 64'hA5A50F0F);
        tick();

        // Reset mid-WAIT on a fetch (fetch was last owner, so without reset a tie would go to data)
        if_req = 1'b1;
        if_addr = 32'h30;
        #1;
        chk("rw_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 1'b0;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        #1;
        chk("rw_in_wait", 64'(dbg_state), 64'd2);
        rst = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1;
        #1;
        chk("rw_state", 64'(dbg_state), 64'd0);
        chk("rw_m_req", 64'(m_req), 64'd0);
        chk("rw_m_addr", 64'(m_addr), 64'd0);
        chk("rw_m_be", 64'(m_be), 64'd0);
        chk("rw_gnt", 64'(if_gnt | d_gnt), 64'd0);
        tick();
        m_rvalid = 1'b1;
        m_rdata = 32'h0BAD0BAD;
        #1;
        chk("rw_if_rvalid", 64'(if_rvalid), 64'd0);
        tick();
        rst = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        if_addr = 32'h100;
        d_addr = 32'h200;
        #1;
        chk("rw_no_pulse", 64'(if_rvalid | d_rvalid), 64'd0);

        // Round-robin with both requests held
        rr_step(1'b1, 32'h11110001);
        rr_step(1'b0, 32'h22220002);
        rr_step(1'b1, 32'h33330003);
        rr_step(1'b0, 32'h44440004);
        if_req = 1'b0;
        d_req = 1'b0;

        // Timeout (TIMEOUT_CYCLES = 5 instance), memory never acks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h80;
        #1;
        chk("to_d_gnt", 64'(t_d_gnt), 64'd1);
        tick();
        d_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to_m_req_held", 64'(t_m_req), 64'd1);
            tick();
        end
        chk("to_m_req_drop", 64'(t_m_req), 64'd0);
        chk("to_d_rvalid_early", 64'(t_d_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b1;
        m_rdata = 32'hBAD0BAD0;
        #1;
        chk("to_d_rvalid", 64'(t_d_rvalid), 64'd1);
        chk("to_d_err", 64'(t_d_err), 64'd1);
        chk("to_d_rdata", 64'(t_d_rdata), 64'd0);
        chk("to_if_rvalid", 64'(t_if_rvalid), 64'd0);
        tick();
        chk("to_d_rvalid_after", 64'(t_d_rvalid), 64'd0);
        chk("to_d_err_after", 64'(t_d_err), 64'd0);
        chk("to_state_idle", 64'(t_dbg_state), 64'd0);
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("to_late_ignored", 64'(t_d_rvalid | t_if_rvalid), 64'd0);

        // Exact boundary: response in the cycle the counter reaches the limit
        if_req = 1'b1;
        if_addr = 32'h44;
        #1;
        chk("bd_if_gnt", 64'(t_if_gnt), 64'd1);
        tick();
        if_req = 1'b0;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        repeat (4) tick();
        m_rvalid = 1'b1;
        m_rdata = 32'hCAFE0001;
        #1;
        chk("bd_m_req", 64'(t_m_req), 64'd0);
        chk("bd_no_early", 64'(t_if_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b0;
        m_rdata = '0;
        #1;
        chk("bd_if_rvalid", 64'(t_if_rvalid), 64'd1);
        chk("bd_if_err", 64'(t_if_err), 64'd0);
        chk("bd_if_rdata", 64'(t_if_rdata), 64'hCAFE0001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
